ulbf_coeffs_bridge: RTL and testbench

Parametrised successor to the coefficient BRAM port adapter in the ULBF PL datapath. It bridges the 32-bit AXI BRAM-controller port onto NUM_BANKS coefficient memories of width MEM_DW and steers lane data and byte enables. It pipelines read data to match BRAM latency and owns a CSR region that drives ping-pong bank swaps synchronised to the consumer's frame boundary.

---
 rtl/ulbf_coeffs_pkg.sv | 29 ++
 rtl/ulbf_coeffs_csr.sv | 94 +++++++++
 rtl/ulbf_coeffs_bridge.sv | 124 ++++++++++++
 tb/tb_ulbf_coeffs_bridge.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ulbf_coeffs_pkg.sv
// Shared constants and types for the ULBF coefficient BRAM bridge.
// CSR map, register bit positions and the bank-swap state encoding.
package ulbf_coeffs_pkg;

    localparam logic [2:0] CSR_CONTROL  = 3'd0;
    localparam logic [2:0] CSR_STATUS   = 3'd1;
    localparam logic [2:0] CSR_WR_COUNT = 3'd2;
    localparam logic [2:0] CSR_INFO     = 3'd3;

    localparam int CTRL_SWAP_REQ = 0;
    localparam int CTRL_ERR_CLR  = 1;

    localparam int STAT_BANK_LSB = 0;
    localparam int STAT_PENDING  = 2;
    localparam int STAT_ERR      = 3;

    localparam logic [7:0] VERSION = 8'h02;

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } swap_state_t;

    // Bank the host may touch while the consumer reads 'bank'.
    function automatic logic [1:0] next_bank(input logic [1:0] bank, input int num_banks);
        return (int'(bank) >= num_banks - 1) ? 2'd0 : bank + 2'd1;
    endfunction

endpackage

// File: rtl/ulbf_coeffs_csr.sv
// CSR block of the coefficient bridge: swap FSM, active bank, write counter, sticky ERR.
//   state   | meaning
//   IDLE    | no swap requested; frame_start is ignored
//   PENDING | swap requested; next frame_start promotes the shadow bank
module ulbf_coeffs_csr
    import ulbf_coeffs_pkg::*;
#(
    parameter int MEM_DW    = 64,
    parameter int NUM_BANKS = 2,
    parameter int RD_LAT    = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        csr_wr,
    input  logic [2:0]  csr_offset,
    input  logic [1:0]  ctl,
    input  logic        mem_wr,
    input  logic        frame_start,
    output logic [31:0] rdata,
    output logic [1:0]  active_bank,
    output logic [1:0]  shadow_bank,
    output logic        swap_done
);

    swap_state_t state_q;
    swap_state_t state_d;
    logic        swap_fire;
    logic        ctrl_wr;
    logic        pending;
    logic        err_q;
    logic [15:0] wr_count;

    assign ctrl_wr     = csr_wr && (csr_offset == CSR_CONTROL);
    assign pending     = (state_q == PENDING);
    assign shadow_bank = next_bank(active_bank, NUM_BANKS);

    always_comb begin
        state_d   = state_q;
        swap_fire = 1'b0;
        case (state_q)
            IDLE: begin
                // a request landing on a frame boundary waits for the next one
                if (ctrl_wr && ctl[CTRL_SWAP_REQ]) state_d = PENDING;
            end
            PENDING: begin
                if (frame_start) begin
                    state_d   = IDLE;
                    swap_fire = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            active_bank <= 2'd0;
            wr_count    <= 16'd0;
            err_q       <= 1'b0;
            swap_done   <= 1'b0;
        end else begin
            state_q   <= state_d;
            swap_done <= swap_fire;
            if (swap_fire) begin
                active_bank <= shadow_bank;
                wr_count    <= 16'd0;
            end else if (mem_wr && (wr_count != 16'hFFFF)) begin
                wr_count <= wr_count + 16'd1;
            end
            if (mem_wr && pending) begin
                err_q <= 1'b1;
            end else if (ctrl_wr && ctl[CTRL_ERR_CLR]) begin
                err_q <= 1'b0;
            end
        end
    end

    always_comb begin
        rdata = '0;
        case (csr_offset)
            CSR_CONTROL: rdata[CTRL_SWAP_REQ] = pending;
            CSR_STATUS: begin
                rdata[STAT_BANK_LSB +: 2] = active_bank;
                rdata[STAT_PENDING]       = pending;
                rdata[STAT_ERR]           = err_q;
            end
            CSR_WR_COUNT: rdata[15:0] = wr_count;
            CSR_INFO:     rdata = {16'(MEM_DW), 4'(RD_LAT), 4'(NUM_BANKS), VERSION};
            default:      rdata = '0;
        endcase
    end

endmodule

// File: rtl/ulbf_coeffs_bridge.sv
// Bridges the 32-bit AXI BRAM-controller port onto NUM_BANKS coefficient memories,
// steering lanes/byte enables and aligning read data to the BRAM latency.
module ulbf_coeffs_bridge
    import ulbf_coeffs_pkg::*;
#(
    parameter int MEM_DW    = 64,
    parameter int MEM_AW    = 16,
    parameter int NUM_BANKS = 2,
    parameter int RD_LAT    = 1
) (
    input  logic                          BRAM_PORTA_clk,
    input  logic                          BRAM_PORTA_rst,
    input  logic [19:0]                   BRAM_PORTA_addr,
    input  logic [31:0]                   BRAM_PORTA_din,
    output logic [31:0]                   BRAM_PORTA_dout,
    input  logic                          BRAM_PORTA_en,
    input  logic                          BRAM_PORTA_we,
    output logic [NUM_BANKS-1:0]          mem_ena,
    output logic [MEM_DW/8-1:0]           mem_wea,
    output logic [MEM_AW-1:0]             mem_addra,
    output logic [MEM_DW-1:0]             mem_dina,
    input  logic [NUM_BANKS*MEM_DW-1:0]   mem_douta,
    input  logic                          frame_start,
    output logic [1:0]                    active_bank,
    output logic                          swap_done
);

    localparam int LANES  = MEM_DW / 32;
    localparam int LANE_W = $clog2(LANES);
    localparam int LSB    = 2 + LANE_W;
    localparam int WEW    = MEM_DW / 8;

    typedef struct packed {
        logic              vld;
        logic              csr;
        logic [1:0]        bank;
        logic [LANE_W-1:0] lane;
        logic [31:0]       cdata;
    } rd_stage_t;

    logic              is_csr;
    logic              mem_access;
    logic              mem_wr;
    logic              csr_wr;
    logic              rd_issue;
    logic [LANE_W-1:0] lane;
    logic [18:0]       word_idx;
    logic [1:0]        shadow_bank;
    logic [31:0]       csr_rdata;
    logic [31:0]       mem_word;
    logic [31:0]       dout_q;
    rd_stage_t         pipe [RD_LAT];
    rd_stage_t         last;
    logic              unused_addr;

    assign unused_addr = ^BRAM_PORTA_addr[1:0];

    assign is_csr     = BRAM_PORTA_addr[19];
    assign mem_access = BRAM_PORTA_en && !is_csr && !BRAM_PORTA_rst;
    assign mem_wr     = mem_access && BRAM_PORTA_we;
    assign csr_wr     = BRAM_PORTA_en && BRAM_PORTA_we && is_csr;
    assign rd_issue   = BRAM_PORTA_en && !BRAM_PORTA_we;

    assign lane      = BRAM_PORTA_addr[LSB-1:2];
    assign word_idx  = BRAM_PORTA_addr[18:0] >> LSB;
    assign mem_addra = MEM_AW'(word_idx);
    assign mem_ena   = mem_access ? (NUM_BANKS'(1) << shadow_bank) : '0;
    assign mem_wea   = mem_wr ? (WEW'(4'hF) << {lane, 2'b00}) : '0;
    assign mem_dina  = {LANES{BRAM_PORTA_din}};

    ulbf_coeffs_csr #(
        .MEM_DW    (MEM_DW),
        .NUM_BANKS (NUM_BANKS),
        .RD_LAT    (RD_LAT)
    ) u_csr (
        .clk         (BRAM_PORTA_clk),
        .rst         (BRAM_PORTA_rst),
        .csr_wr      (csr_wr),
        .csr_offset  (BRAM_PORTA_addr[4:2]),
        .ctl         (BRAM_PORTA_din[1:0]),
        .mem_wr      (mem_wr),
        .frame_start (frame_start),
        .rdata       (csr_rdata),
        .active_bank (active_bank),
        .shadow_bank (shadow_bank),
        .swap_done   (swap_done)
    );

    // Bank index is frozen at issue so a swap during the read cannot redirect it.
    always_ff @(posedge BRAM_PORTA_clk) begin
        if (BRAM_PORTA_rst) begin
            for (int i = 0; i < RD_LAT; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= '{vld: rd_issue, csr: is_csr, bank: shadow_bank,
                         lane: lane, cdata: csr_rdata};
            for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign last = pipe[RD_LAT-1];

    always_comb begin
        mem_word = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            for (int l = 0; l < LANES; l++) begin
                if ((last.bank == 2'(b)) && (last.lane == LANE_W'(l)))
                    mem_word = mem_douta[b*MEM_DW + l*32 +: 32];
            end
        end
    end

    // The BRAM output register is the final latency stage, so the lane mux is
    // transparent on the completing cycle and dout_q holds the value afterwards.
    always_comb begin
        BRAM_PORTA_dout = dout_q;
        if (last.vld) BRAM_PORTA_dout = last.csr ? last.cdata : mem_word;
    end

    always_ff @(posedge BRAM_PORTA_clk) begin
        if (BRAM_PORTA_rst) dout_q <= '0;
        else                dout_q <= BRAM_PORTA_dout;
    end

endmodule

// File: tb/tb_ulbf_coeffs_bridge.sv
// Scoreboard bench for ulbf_coeffs_bridge: directed scenarios plus random traffic
// against a behavioural model of banks, CSRs and the swap protocol.
module tb_ulbf_coeffs_bridge;

    localparam int DW    = 128;
    localparam int AW    = 16;
    localparam int NB    = 3;
    localparam int RL    = 2;
    localparam int LANES = DW / 32;
    localparam int LSB   = 2 + $clog2(LANES);
    localparam logic [19:0] CSR = 20'h80000;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             en = 1'b0;
    logic             we = 1'b0;
    logic             fs = 1'b0;
    logic [19:0]      addr = '0;
    logic [31:0]      din = '0;
    logic [31:0]      dout;
    logic [NB-1:0]    mem_ena;
    logic [DW/8-1:0]  mem_wea;
    logic [AW-1:0]    mem_addra;
    logic [DW-1:0]    mem_dina;
    logic [NB*DW-1:0] mem_douta;
    logic [1:0]       active_bank;
    logic             swap_done;

    ulbf_coeffs_bridge #(.MEM_DW(DW), .MEM_AW(AW), .NUM_BANKS(NB), .RD_LAT(RL)) dut (
        .BRAM_PORTA_clk  (clk),
        .BRAM_PORTA_rst  (rst),
        .BRAM_PORTA_addr (addr),
        .BRAM_PORTA_din  (din),
        .BRAM_PORTA_dout (dout),
        .BRAM_PORTA_en   (en),
        .BRAM_PORTA_we   (we),
        .mem_ena         (mem_ena),
        .mem_wea         (mem_wea),
        .mem_addra       (mem_addra),
        .mem_dina        (mem_dina),
        .mem_douta       (mem_douta),
        .frame_start     (fs),
        .active_bank     (active_bank),
        .swap_done       (swap_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    endtask

    function automatic int key(input int b, input int w, input int l);
        return b * (1 << 22) + w * 16 + l;
    endfunction

    function automatic logic [31:0] init_val(input int b, input int w, input int l);
        return {8'(b), 16'(w), 8'(l)} ^ 32'hC0DE_0000;
    endfunction

    // Emulated BRAM: byte-enabled storage plus an RL-cycle output pipeline.
    logic [31:0]      bram_store [int];
    logic [NB*DW-1:0] rd_pipe [RL];
    assign mem_douta = rd_pipe[RL-1];

    always @(posedge clk) begin
        logic [NB*DW-1:0] rd;
        logic [31:0]      w;
        int               k;
        rd = rd_pipe[0];
        for (int b = 0; b < NB; b++) begin
            if (mem_ena[b]) begin
                for (int l = 0; l < LANES; l++) begin
                    k = key(b, int'(mem_addra), l);
                    w = bram_store.exists(k) ? bram_store[k] : init_val(b, int'(mem_addra), l);
                    for (int j = 0; j < 4; j++)
                        if (mem_wea[l*4+j]) w[j*8 +: 8] = mem_dina[l*32 + j*8 +: 8];
                    if (mem_wea[l*4 +: 4] != 4'h0) bram_store[k] = w;
                    rd[b*DW + l*32 +: 32] = w;
                end
            end
        end
        rd_pipe[0] <= rd;
        for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
    end

    // Reference model state
    logic [1:0]  m_active = 2'd0;
    bit          m_pending = 1'b0;
    bit          m_err = 1'b0;
    logic [15:0] m_wc = 16'd0;
    logic [31:0] m_mem [int];

    typedef struct { int due; logic [1:0] act; bit sd; bit rst; } obs_t;
    typedef struct { int due; logic [31:0] data; } rd_t;
    obs_t obsq[$];
    rd_t  rdq[$];

    function automatic logic [31:0] model_csr(input int off);
        case (off)
            0: return {31'd0, m_pending};
            1: return {28'd0, m_err, m_pending, m_active};
            2: return {16'd0, m_wc};
            3: return {16'(DW), 4'(RL), 4'(NB), 8'h02};
            default: return 32'd0;
        endcase
    endfunction

    task automatic step(input bit i_rst, input bit i_en, input bit i_we,
                        input logic [19:0] i_addr, input logic [31:0] i_din, input bit i_fs);
        int          n, sh, ln, wd, off, k;
        bit          is_mem, is_csr, swap;
        logic [511:0] e_ena, e_wea, e_dina;
        logic [31:0] rdata;
        @(posedge clk);
        #1;
        rst = i_rst; en = i_en; we = i_we; addr = i_addr; din = i_din; fs = i_fs;
        @(negedge clk);
        #1;
        n      = cyc;
        sh     = (int'(m_active) + 1) % NB;
        ln     = int'(i_addr[19:2]) % LANES;
        wd     = int'(i_addr[18:0] >> LSB) % (1 << AW);
        off    = int'(i_addr[4:2]);
        is_mem = i_en && !i_addr[19] && !i_rst;
        is_csr = i_en && i_addr[19];

        e_ena = is_mem ? (512'd1 << sh) : 512'd0;
        e_wea = (is_mem && i_we) ? (512'hF << (4 * ln)) : 512'd0;
        chk("mem_ena", 512'(mem_ena), e_ena);
        chk("mem_wea", 512'(mem_wea), e_wea);
        if (is_mem) chk("mem_addra", 512'(mem_addra), 512'(wd));
        if (is_mem && i_we) begin
            e_dina = '0;
            for (int l = 0; l < LANES; l++) e_dina[l*32 +: 32] = i_din;
            chk("mem_dina", 512'(mem_dina), e_dina);
        end

        if (i_rst) begin
            m_active = 2'd0; m_pending = 0; m_err = 0; m_wc = 16'd0;
            rdq.delete();
            obsq.push_back('{n + 1, 2'd0, 1'b0, 1'b1});
            return;
        end

        if (i_en && !i_we) begin
            if (is_csr) rdata = model_csr(off);
            else begin
                k = key(sh, wd, ln);
                rdata = m_mem.exists(k) ? m_mem[k] : init_val(sh, wd, ln);
            end
            rdq.push_back('{n + RL, rdata});
        end

        swap = m_pending && i_fs;
        if (is_mem && i_we) begin
            m_mem[key(sh, wd, ln)] = i_din;
            if (m_pending) m_err = 1;
            if (m_wc != 16'hFFFF) m_wc = m_wc + 16'd1;
        end else if (is_csr && i_we && off == 0) begin
            if (i_din[1]) m_err = 0;
            if (i_din[0] && !m_pending) begin
                m_pending = 1;
                swap = 0;
            end
        end
        if (swap) begin
            m_active  = 2'(sh);
            m_pending = 0;
            m_wc      = 16'd0;
        end
        obsq.push_back('{n + 1, m_active, swap, 1'b0});
    endtask

    logic [31:0] hold = '0;
    always @(negedge clk) begin
        if (obsq.size() > 0 && obsq[0].due == cyc) begin
            chk("active_bank", 512'(active_bank), 512'(obsq[0].act));
            chk("swap_done", 512'(swap_done), 512'(obsq[0].sd));
            if (obsq[0].rst) hold = '0;
            void'(obsq.pop_front());
            if (rdq.size() > 0 && rdq[0].due == cyc) begin
                chk("dout", 512'(dout), 512'(rdq[0].data));
                hold = rdq[0].data;
                void'(rdq.pop_front());
            end else begin
                chk("dout_hold", 512'(dout), 512'(hold));
            end
        end
    end

    task automatic idle(input int cnt);
        for (int i = 0; i < cnt; i++) step(0, 0, 0, 20'h0, 32'h0, 0);
    endtask

    task automatic csr_rd(input int off);
        step(0, 1, 0, CSR | 20'(off << 2), 32'h0, 0);
    endtask

    initial begin
        logic [19:0] a;
        int          op;
        for (int i = 0; i < 3; i++) step(1, 0, 0, 20'h0, 32'h0, 0);

        // lane steering write/read-back, INFO
        step(0, 1, 1, 20'h00018, 32'hA5A5_0001, 0);
        step(0, 1, 0, 20'h00018, 32'h0, 0);
        idle(2);
        csr_rd(3);
        idle(2);

        // swap after 5 cycles, pending visible meanwhile
        step(0, 1, 1, CSR, 32'h1, 0);
        for (int i = 0; i < 4; i++) csr_rd(1);
        step(0, 0, 0, 20'h0, 32'h0, 1);
        csr_rd(2);
        csr_rd(1);
        idle(2);

        // request coinciding with frame_start waits for the next one
        step(0, 1, 1, CSR, 32'h1, 1);
        csr_rd(1);
        step(0, 0, 0, 20'h0, 32'h0, 1);
        csr_rd(1);
        idle(2);

        // write while pending sets ERR, ERR_CLR clears it
        step(0, 1, 1, CSR, 32'h1, 0);
        step(0, 1, 1, 20'h00024, 32'h1234_5678, 0);
        csr_rd(1);
        step(0, 1, 1, CSR, 32'h2, 0);
        csr_rd(1);
        step(0, 0, 0, 20'h0, 32'h0, 1);
        step(0, 1, 0, 20'h00024, 32'h0, 0);
        idle(3);

        // reset while pending with a read in flight
        step(0, 1, 1, CSR, 32'h1, 0);
        step(0, 1, 0, 20'h00018, 32'h0, 0);
        step(1, 0, 0, 20'h0, 32'h0, 0);
        step(0, 0, 0, 20'h0, 32'h0, 1);
        csr_rd(1);
        idle(3);

        for (int it = 0; it < 600; it++) begin
            op = int'($urandom_range(0, 7));
            if (op <= 2) begin
                a = 20'(($urandom_range(0, 7) << LSB) | ($urandom_range(0, LANES - 1) << 2) | $urandom_range(0, 3));
                if ($urandom_range(0, 9) == 0) a = 20'($urandom) & 20'h7FFFF;
            end else begin
                a = CSR | (20'($urandom) & 20'h7FFE0) | 20'($urandom_range(0, 4) << 2);
                if ($urandom_range(0, 3) != 0 && op == 6) a[4:2] = 3'd0;
            end
            step($urandom_range(0, 249) == 0,
                 op != 7,
                 (op == 0 || op == 1 || op == 6),
                 a,
                 (op == 6) ? 32'($urandom_range(0, 3)) : $urandom,
                 $urandom_range(0, 6) == 0);
        end

        idle(RL + 3);
        @(posedge clk);
        @(negedge clk);
        #2;
        chk("drain_rdq", 512'(rdq.size()), 512'd0);
        chk("drain_obsq", 512'(obsq.size()), 512'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
